// File: rtl/led_display_pkg.sv
// Shared constants for the seven-segment display path: segment patterns and
// digit-enable encodings.
package led_display_pkg;

    typedef logic [1:0] sel_t;
    typedef logic [6:0] seg_t;   // {g, f, e, d, c, b, a}
    typedef logic [3:0] led_t;   // {led4, led3, led2, led1}, active-low

    localparam seg_t SEG_BLANK = 7'b0000000;

    // Codes 10-15 are not valid BCD and map to a blank digit
    localparam seg_t SEG_TABLE [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, SEG_BLANK,  SEG_BLANK,
        SEG_BLANK,  SEG_BLANK,  SEG_BLANK,  SEG_BLANK
    };

    localparam led_t LED_ALL_OFF = 4'b1111;

    // Indexed by scan position 0..3 (digit 1..4)
    localparam led_t LED_SEL [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to seven-segment decoder; non-BCD codes give a blank digit.
module seg7_decode
    import led_display_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_TABLE[bcd];
    end

endmodule

// File: rtl/led_display.sv
// Four-digit multiplexed seven-segment driver: scans one digit per SCAN_DIV
// clocks onto a shared, registered segment bus with active-low digit enables.
module led_display
    import led_display_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 1,
    parameter int unsigned DP_DIGIT = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] numcount1_out,
    input  logic [3:0] numcount2_out,
    input  logic [3:0] numcount3_out,
    input  logic [3:0] numcount4_out,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    output logic       e,
    output logic       f,
    output logic       g,
    output logic       h,
    output logic       led1,
    output logic       led2,
    output logic       led3,
    output logic       led4
);

    localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    sel_t             sel_q, sel_d;
    logic [3:0]       digit_mux;
    seg_t             seg_dec;
    logic             dp_hit;

    seg_t seg_q;
    logic h_q;
    led_t led_q;

    always_comb begin
        digit_mux = numcount1_out;
        unique case (sel_q)
            2'd0: digit_mux = numcount1_out;
            2'd1: digit_mux = numcount2_out;
            2'd2: digit_mux = numcount3_out;
            2'd3: digit_mux = numcount4_out;
            default: digit_mux = numcount1_out;
        endcase
    end

    seg7_decode u_decode (
        .bcd (digit_mux),
        .seg (seg_dec)
    );

    // DP_DIGIT of 0 never matches, so the decimal point stays dark
    always_comb begin
        dp_hit = (DP_DIGIT != 0) && ((32'(sel_q) + 32'd1) == DP_DIGIT);
    end

    always_comb begin
        div_d = div_q + 1'b1;
        sel_d = sel_q;
        if (div_q == DIV_LAST) begin
            div_d = '0;
            sel_d = sel_q + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q <= '0;
            sel_q <= '0;
            seg_q <= SEG_BLANK;
            h_q   <= 1'b0;
            led_q <= LED_ALL_OFF;
        end else begin
            div_q <= div_d;
            sel_q <= sel_d;
            seg_q <= seg_dec;
            h_q   <= dp_hit;
            led_q <= LED_SEL[sel_q];
        end
    end

    assign a    = seg_q[0];
    assign b    = seg_q[1];
    assign c    = seg_q[2];
    assign d    = seg_q[3];
    assign e    = seg_q[4];
    assign f    = seg_q[5];
    assign g    = seg_q[6];
    assign h    = h_q;
    assign led1 = led_q[0];
    assign led2 = led_q[1];
    assign led3 = led_q[2];
    assign led4 = led_q[3];

endmodule

// File: tb/tb_led_display.sv
// Scoreboard bench for led_display: a fast-scan instance and a divided-scan
// instance share the inputs and are compared against a reference model.
`timescale 1ns/1ps
module tb_led_display;

    logic       clk;
    logic       rst;
    logic [3:0] n1, n2, n3, n4;

    logic a1, b1, c1, d1, e1, f1, g1, h1, l11, l12, l13, l14;
    logic a5, b5, c5, d5, e5, f5, g5, h5, l51, l52, l53, l54;

    logic [11:0] w1, w5;
    assign w1 = {l14, l13, l12, l11, g1, f1, e1, d1, c1, b1, a1, h1};
    assign w5 = {l54, l53, l52, l51, g5, f5, e5, d5, c5, b5, a5, h5};

    localparam logic [11:0] WORD_OFF = 12'hF00;

    led_display #(.SCAN_DIV(1), .DP_DIGIT(3)) dut (
        .clk (clk), .rst (rst),
        .numcount1_out (n1), .numcount2_out (n2),
        .numcount3_out (n3), .numcount4_out (n4),
        .a (a1), .b (b1), .c (c1), .d (d1), .e (e1), .f (f1), .g (g1), .h (h1),
        .led1 (l11), .led2 (l12), .led3 (l13), .led4 (l14)
    );

    led_display #(.SCAN_DIV(5), .DP_DIGIT(3)) dut5 (
        .clk (clk), .rst (rst),
        .numcount1_out (n1), .numcount2_out (n2),
        .numcount3_out (n3), .numcount4_out (n4),
        .a (a5), .b (b5), .c (c5), .d (d5), .e (e5), .f (f5), .g (g5), .h (h5),
        .led1 (l51), .led2 (l52), .led3 (l53), .led4 (l54)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [11:0] q1[$];
    logic [11:0] q5[$];
    int s1 = 0;
    int s5 = 0;
    int dv5 = 0;

    int run5, last_fall5, cyc;
    bit prev_low5;
    logic [11:0] static_exp [4];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] ref_seg(input logic [3:0] v);
        case (v)
            4'd0: return 7'b0111111;
            4'd1: return 7'b0000110;
            4'd2: return 7'b1011011;
            4'd3: return 7'b1001111;
            4'd4: return 7'b1100110;
            4'd5: return 7'b1101101;
            4'd6: return 7'b1111101;
            4'd7: return 7'b0000111;
            4'd8: return 7'b1111111;
            4'd9: return 7'b1101111;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic logic [11:0] exp_word(input int s);
        logic [3:0] v;
        logic [3:0] led;
        case (s)
            0: v = n1;
            1: v = n2;
            2: v = n3;
            default: v = n4;
        endcase
        led = 4'b1111;
        led[s] = 1'b0;
        return {led, ref_seg(v), (s + 1 == 3)};
    endfunction

    // Reference model: queue the word each instance must show after this edge
    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                s1 = 0;
                s5 = 0;
                dv5 = 0;
                q1.delete();
                q5.delete();
            end else begin
                q1.push_back(exp_word(s1));
                s1 = (s1 + 1) % 4;
                q5.push_back(exp_word(s5));
                if (dv5 == 4) begin
                    dv5 = 0;
                    s5 = (s5 + 1) % 4;
                end else begin
                    dv5++;
                end
            end
        end
    end

    // Output sampler on the inactive edge
    initial begin
        bit l1low;
        bit ok1, ok5;
        run5 = 0;
        last_fall5 = -1;
        prev_low5 = 1'b0;
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                run5 = 0;
                last_fall5 = -1;
                prev_low5 = 1'b0;
                check("rst_off", w1, WORD_OFF);
                check("rst_off5", w5, WORD_OFF);
            end else begin
                if (q1.size() > 0) check("scan1", w1, q1.pop_front());
                if (q5.size() > 0) check("scan5", w5, q5.pop_front());
                ok1 = ($countones(~{l14, l13, l12, l11}) <= 1);
                ok5 = ($countones(~{l54, l53, l52, l51}) <= 1);
                check("onehot1", {11'b0, ok1}, 12'd1);
                check("onehot5", {11'b0, ok5}, 12'd1);
                l1low = (l51 == 1'b0);
                if (l1low && !prev_low5) begin
                    if (last_fall5 >= 0) check("period5", 12'(cyc - last_fall5), 12'd20);
                    last_fall5 = cyc;
                end
                if (!l1low && prev_low5) check("hold5", 12'(run5), 12'd5);
                run5 = l1low ? run5 + 1 : 0;
                prev_low5 = l1low;
            end
        end
    end

    task automatic wait_digit4(input logic [6:0] seg);
        bit found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (l14 == 1'b0 && {g1, f1, e1, d1, c1, b1, a1} == seg) begin
                found = 1'b1;
                break;
            end
        end
        check("live_d4", {11'b0, found}, 12'd1);
    endtask

    initial begin
        bit seen;
        static_exp[0] = {4'b1110, 7'b1011011, 1'b0};
        static_exp[1] = {4'b1101, 7'b1101101, 1'b0};
        static_exp[2] = {4'b1011, 7'b1111101, 1'b1};
        static_exp[3] = {4'b0111, 7'b1001111, 1'b0};

        rst = 1'b1;
        n1 = 4'd8; n2 = 4'd8; n3 = 4'd8; n4 = 4'd8;
        repeat (3) begin
            @(negedge clk);
            n1 = 4'($urandom_range(0, 15));
            n4 = 4'($urandom_range(0, 15));
        end
        #1 check("rst_hold", w1, WORD_OFF);

        // Static scan: digits 4..1 = 3,6,5,2
        n1 = 4'd2; n2 = 4'd5; n3 = 4'd6; n4 = 4'd3;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("static", w1, static_exp[i % 4]);
        end

        // Live update of the leftmost digit
        n4 = 4'd3;
        wait_digit4(7'b1001111);
        repeat (6) @(negedge clk);
        n4 = 4'd4;
        wait_digit4(7'b1100110);
        repeat (6) @(negedge clk);
        n4 = 4'd5;
        wait_digit4(7'b1101101);
        repeat (6) @(negedge clk);

        // Illegal BCD on digit 2
        n2 = 4'hC;
        repeat (12) @(negedge clk);
        n2 = 4'd5;

        // Random traffic including illegal codes
        for (int i = 0; i < 900; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 3))
                    0: n1 = 4'($urandom_range(0, 15));
                    1: n2 = 4'($urandom_range(0, 15));
                    2: n3 = 4'($urandom_range(0, 15));
                    default: n4 = 4'($urandom_range(0, 15));
                endcase
            end
        end

        // Mid-scan reset while digit 3 is lit
        n1 = 4'd2; n2 = 4'd5; n3 = 4'd6; n4 = 4'd3;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (l13 == 1'b0) begin
                seen = 1'b1;
                break;
            end
        end
        check("wait_led3", {11'b0, seen}, 12'd1);
        #2 rst = 1'b1;
        #1 check("midrst_off", w1, WORD_OFF);
        check("midrst_off5", w5, WORD_OFF);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("restart", w1, static_exp[0]);
        check("restart5", w5, static_exp[0]);
        repeat (45) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
